funcs_arb: RTL and testbench

FUNCS_ARB -- requirements
Module: funcs_arb

---
 rtl/funcs_arb_pkg.sv | 24 ++
 rtl/funcs_arb_if.sv | 27 ++
 rtl/funcs_rr_arb.sv | 36 +++
 rtl/funcs_arb.sv | 140 ++++++++++++++
 tb/tb_funcs_arb.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/funcs_arb_pkg.sv
// Shared types and constants for the two-requester funcs arbiter: opcodes,
// FSM states, the illegal-op result fill and the default datapath width.
package funcs_arb_pkg;

    localparam int DW_DEFAULT = 8;

    // Every bit of the result is set to this value when the opcode is illegal
    localparam logic ILLEGAL_FILL = 1'b1;

    typedef enum logic [2:0] {
        OP_ADD12 = 3'd0,
        OP_SUB34 = 3'd1,
        OP_ADD   = 3'd2,
        OP_XOR   = 3'd3,
        OP_AND   = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/funcs_arb_if.sv
// Request/response bus between the two requesters (master) and funcs_arb (slave).
// Per-requester fields are packed with requester 0 in the low slice.
interface funcs_arb_if
    import funcs_arb_pkg::*;
#(
    parameter int DW = DW_DEFAULT
);
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [5:0]      req_op;
    logic [2*DW-1:0] req_a;
    logic [2*DW-1:0] req_b;
    logic [1:0]      resp_valid;
    logic [1:0]      resp_ready;
    logic [DW-1:0]   resp_data;
    logic            resp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/funcs_rr_arb.sv
// Two-way round-robin grant: a sole requester wins, a tie goes to the requester
// not granted last. The pointer only moves when a grant is actually taken.
module funcs_rr_arb
    import funcs_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);
    logic last_q, last_d;

    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        if (update) begin
            last_d = gnt[1];
        end
    end

    // Reset as if requester 1 went last so requester 0 wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/funcs_arb.sv
// Arbitrates two requesters onto the external funcs datapath, one op per
// IDLE->ISSUE->RESP round. Grant counters exist only with FUNCS_ARB_STATS_EN.
module funcs_arb
    import funcs_arb_pkg::*;
#(
    parameter int DW = DW_DEFAULT
)(
    input  logic          clk,
    input  logic          rst,
    funcs_arb_if.slave    bus,
    output logic [DW-1:0] fn_a,
    output logic [DW-1:0] fn_b,
    output logic [DW-1:0] fn_m,
    output logic [DW-1:0] fn_n,
    output logic          fn_h,
    output logic          fn_i,
    input  logic [DW-1:0] fn_c,
    input  logic [DW-1:0] fn_d,
    input  logic [DW-1:0] fn_o,
    input  logic          fn_j,
    input  logic          fn_k,
    output logic [15:0]   gnt_cnt0,
    output logic [15:0]   gnt_cnt1
);
    state_e        state_q, state_d;
    logic          sel_q, sel_d;
    logic [2:0]    op_q, op_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic          err_q, err_d;
    logic [1:0]    gnt;
    logic          accept;

    funcs_rr_arb u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req_valid),
        .update (accept),
        .gnt    (gnt)
    );

    // Offers are withheld during the reset cycle itself as well as outside IDLE
    assign bus.req_ready = (state_q == S_IDLE && !rst) ? gnt : 2'b00;
    assign accept        = |bus.req_ready;

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        op_d           = op_q;
        a_d            = a_q;
        b_d            = b_q;
        res_d          = res_q;
        err_d          = err_q;
        fn_a           = '0;
        fn_b           = '0;
        fn_m           = '0;
        fn_n           = '0;
        fn_h           = 1'b0;
        fn_i           = 1'b0;
        bus.resp_valid = 2'b00;
        bus.resp_data  = '0;
        bus.resp_err   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sel_d   = gnt[1];
                    op_d    = gnt[1] ? bus.req_op[5:3]      : bus.req_op[2:0];
                    a_d     = gnt[1] ? bus.req_a[2*DW-1:DW] : bus.req_a[DW-1:0];
                    b_d     = gnt[1] ? bus.req_b[2*DW-1:DW] : bus.req_b[DW-1:0];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                err_d = 1'b0;
                case (op_q)
                    OP_ADD12: begin fn_a = a_q; res_d = fn_c; end
                    OP_SUB34: begin fn_b = a_q; res_d = fn_d; end
                    OP_ADD:   begin fn_m = a_q; fn_n = b_q; res_d = fn_o; end
                    OP_XOR:   begin fn_h = a_q[0]; fn_i = b_q[0]; res_d = {{(DW-1){1'b0}}, fn_j}; end
                    OP_AND:   begin fn_h = a_q[0]; fn_i = b_q[0]; res_d = {{(DW-1){1'b0}}, fn_k}; end
                    default:  begin res_d = {DW{ILLEGAL_FILL}}; err_d = 1'b1; end
                endcase
                state_d = S_RESP;
            end
            S_RESP: begin
                bus.resp_valid[sel_q] = 1'b1;
                bus.resp_data         = res_q;
                bus.resp_err          = err_q;
                if (bus.resp_ready[sel_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand/result holding registers are only observed in ISSUE/RESP
    always_ff @(posedge clk) begin
        sel_q <= sel_d;
        op_q  <= op_d;
        a_q   <= a_d;
        b_q   <= b_d;
        res_q <= res_d;
        err_q <= err_d;
    end

`ifdef FUNCS_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (bus.req_ready[0] && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
        if (bus.req_ready[1] && cnt1_q != 16'hFFFF) cnt1_d = cnt1_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign gnt_cnt0 = cnt0_q;
    assign gnt_cnt1 = cnt1_q;
`else
    assign gnt_cnt0 = 16'd0;
    assign gnt_cnt1 = 16'd0;
`endif
endmodule

// File: tb/tb_funcs_arb.sv
// Scoreboard bench for funcs_arb: the driver updates a transaction-level model
// at each rising edge and queues expected responses; a negedge monitor checks.
module tb_funcs_arb;
    import funcs_arb_pkg::*;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    funcs_arb_if #(.DW(DW)) bus();

    logic [DW-1:0] fn_a, fn_b, fn_m, fn_n, fn_c, fn_d, fn_o;
    logic          fn_h, fn_i, fn_j, fn_k;
    logic [15:0]   gnt_cnt0, gnt_cnt1;

    // External datapath behaviour
    assign fn_c = fn_a + DW'(12);
    assign fn_d = fn_b - DW'(34);
    assign fn_o = fn_m + fn_n;
    assign fn_j = fn_h ^ fn_i;
    assign fn_k = fn_h & fn_i;

    funcs_arb #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .fn_a(fn_a), .fn_b(fn_b), .fn_m(fn_m), .fn_n(fn_n), .fn_h(fn_h), .fn_i(fn_i),
        .fn_c(fn_c), .fn_d(fn_d), .fn_o(fn_o), .fn_j(fn_j), .fn_k(fn_k),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    typedef struct {
        int            idx;
        logic [2:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   edge_cnt    = 0;
    int   acc_edge    = 0;
    int   cur_idx     = 0;
    int   last_gnt    = 1;
    bit   busy        = 1'b0;
    int   cnt[2]      = '{0, 0};

    function automatic logic [DW-1:0] ref_result(input logic [2:0] op, input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b);
        case (op)
            3'd0:    return a + DW'(12);
            3'd1:    return a - DW'(34);
            3'd2:    return a + b;
            3'd3:    return {{(DW-1){1'b0}}, a[0] ^ b[0]};
            3'd4:    return {{(DW-1){1'b0}}, a[0] & b[0]};
            default: return {DW{1'b1}};
        endcase
    endfunction

    function automatic int winner(input logic [1:0] v, input int last);
        if (v == 2'b11) return (last == 1) ? 0 : 1;
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model update on each rising edge, then inputs may change 1 time unit later
    task automatic step();
        int   w;
        exp_t e;
        @(posedge clk);
        edge_cnt++;
        if (rst) begin
            busy     = 1'b0;
            last_gnt = 1;
            cnt[0]   = 0;
            cnt[1]   = 0;
            sb.delete();
        end else if (!busy) begin
            w = winner(bus.req_valid, last_gnt);
            if (w >= 0) begin
                e.idx  = w;
                e.op   = bus.req_op[3*w +: 3];
                e.a    = bus.req_a[DW*w +: DW];
                e.b    = bus.req_b[DW*w +: DW];
                e.data = ref_result(e.op, e.a, e.b);
                e.err  = (e.op > 3'd4);
                sb.push_back(e);
                grant_log.push_back(w);
                busy     = 1'b1;
                cur_idx  = w;
                acc_edge = edge_cnt;
                last_gnt = w;
                if (cnt[w] < 65535) cnt[w]++;
            end
        end else if (edge_cnt >= acc_edge + 2 && bus.resp_ready[cur_idx]) begin
            busy = 1'b0;
        end
        #1;
    endtask

    task automatic set_req(input int idx, input logic v, input logic [2:0] op,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.req_valid[idx]       = v;
        bus.req_op[3*idx +: 3]   = op;
        bus.req_a[DW*idx +: DW]  = a;
        bus.req_b[DW*idx +: DW]  = b;
    endtask

    task automatic wait_accept(input string name);
        int n = 0;
        while (!busy && n < 10) begin step(); n++; end
        check({name, "_accept"}, 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (busy && n < 30) begin step(); n++; end
        check({name, "_done"}, 64'(busy), 64'd0);
    endtask

    task automatic do_single(input int idx, input logic [2:0] op, input logic [DW-1:0] a,
                             input logic [DW-1:0] b, input int hold);
        bus.resp_ready = 2'b11;
        set_req(idx, 1'b1, op, a, b);
        wait_accept("single");
        bus.req_valid[idx] = 1'b0;
        if (hold > 0) begin
            bus.resp_ready = 2'b00;
            repeat (hold) step();
            bus.resp_ready = 2'b11;
        end
        wait_done("single");
    endtask

    // Monitor: every cycle compare ready, datapath drive, response and counters
    always @(negedge clk) begin : mon
        logic [1:0]    exp_rdy;
        logic [DW-1:0] ea, eb, em, en;
        logic          eh, ei;
        int            w;
        exp_t          e;
        exp_rdy = 2'b00;
        if (!rst && !busy) begin
            w = winner(bus.req_valid, last_gnt);
            if (w >= 0) exp_rdy[w] = 1'b1;
        end
        check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));

        ea = '0; eb = '0; em = '0; en = '0; eh = 1'b0; ei = 1'b0;
        if (busy && edge_cnt == acc_edge && sb.size() > 0) begin
            e = sb[0];
            case (e.op)
                3'd0: ea = e.a;
                3'd1: eb = e.a;
                3'd2: begin em = e.a; en = e.b; end
                3'd3, 3'd4: begin eh = e.a[0]; ei = e.b[0]; end
                default: ;
            endcase
        end
        check("fn_operands", {fn_a, fn_b, fn_m, fn_n, fn_h, fn_i}, {ea, eb, em, en, eh, ei});

        if (busy && edge_cnt >= acc_edge + 1 && sb.size() > 0) begin
            e = sb[0];
            check("resp_valid", 64'(bus.resp_valid), 64'(2'b01 << e.idx));
            check("resp_data",  64'(bus.resp_data),  64'(e.data));
            check("resp_err",   64'(bus.resp_err),   64'(e.err));
            if (bus.resp_ready[e.idx]) void'(sb.pop_front());
        end else begin
            check("resp_idle", {bus.resp_valid, bus.resp_data, bus.resp_err}, 64'd0);
        end

`ifdef FUNCS_ARB_STATS_EN
        check("gnt_cnt", {gnt_cnt0, gnt_cnt1}, {16'(cnt[0]), 16'(cnt[1])});
`else
        check("gnt_cnt", {gnt_cnt0, gnt_cnt1}, 64'd0);
`endif
    end

    initial begin : drv
        int start;
        bus.req_valid  = 2'b00;
        bus.req_op     = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 2'b00;

        // Reset with both requesters asking: nothing may be offered
        rst = 1'b1;
        set_req(0, 1'b1, OP_ADD, 8'h01, 8'h02);
        set_req(1, 1'b1, OP_ADD, 8'h03, 8'h04);
        repeat (3) step();
        bus.req_valid = 2'b00;
        rst = 1'b0;
        step();

        do_single(0, OP_ADD12, 8'h10, 8'h00, 0);
        do_single(1, OP_SUB34, 8'h10, 8'h00, 0);

        // Both valid: last grant was requester 1, so 0,1,0,1,...
        start = grant_log.size();
        bus.resp_ready = 2'b11;
        set_req(0, 1'b1, OP_ADD, 8'hF0, 8'h20);
        set_req(1, 1'b1, OP_ADD, 8'hF0, 8'h20);
        repeat (14) step();
        bus.req_valid = 2'b00;
        wait_done("both");
        check("both_grant_count_ge4", 64'(grant_log.size() - start >= 4), 64'd1);
        for (int k = 0; k < 4 && start + k < grant_log.size(); k++)
            check("both_grant_order", 64'(grant_log[start+k]), 64'(k % 2));

        do_single(0, OP_XOR, 8'h01, 8'h01, 0);
        do_single(0, OP_AND, 8'h01, 8'h01, 0);
        do_single(0, 3'd6,   8'h55, 8'hAA, 0);
        do_single(1, OP_ADD, 8'h7F, 8'h93, 5);

        // Reset during ISSUE abandons the op; then a tie must go to requester 0
        bus.resp_ready = 2'b11;
        set_req(0, 1'b1, OP_ADD12, 8'h22, 8'h00);
        wait_accept("rst_issue");
        bus.req_valid = 2'b00;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (5) step();
        set_req(0, 1'b1, OP_ADD, 8'h01, 8'h01);
        set_req(1, 1'b1, OP_ADD, 8'h02, 8'h02);
        wait_accept("tie_after_rst");
        bus.req_valid = 2'b00;
        check("tie_after_rst_winner", 64'(grant_log[grant_log.size()-1]), 64'd0);
        wait_done("tie_after_rst");

        // Counter scenario from a clean reset: 3 on req0, 2 on req1
        rst = 1'b1;
        step();
        rst = 1'b0;
        do_single(0, OP_ADD12, 8'h01, 8'h00, 0);
        do_single(1, OP_SUB34, 8'h02, 8'h00, 0);
        do_single(0, OP_ADD,   8'h03, 8'h04, 0);
        do_single(1, OP_XOR,   8'h05, 8'h06, 0);
        do_single(0, OP_AND,   8'h07, 8'h08, 0);
`ifdef FUNCS_ARB_STATS_EN
        check("gnt_cnt_3_2", {gnt_cnt0, gnt_cnt1}, {16'd3, 16'd2});
`else
        check("gnt_cnt_off", {gnt_cnt0, gnt_cnt1}, 64'd0);
`endif

        // Randomized traffic with occasional resets
        for (int c = 0; c < 800; c++) begin
            bus.req_valid  = 2'($urandom_range(0, 3));
            bus.req_op     = 6'($urandom);
            bus.req_a      = (2*DW)'($urandom);
            bus.req_b      = (2*DW)'($urandom);
            bus.resp_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            rst            = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        bus.req_valid  = 2'b00;
        bus.resp_ready = 2'b11;
        wait_done("drain");
        step();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
